uart_rx_os: RTL and testbench
=============================

Name: uart_rx_os

Overview:
- Oversampling UART receiver feeding the debug port's command FSM.
- Input: already-synchronized serial line plus the shared 16x baud tick from the baud tick generator.
- Output: one strobed byte per valid 8N1 frame (rx_data / rx_done_tick), with framing-error and busy status.
- Sits between the 3-stage input synchronizer and the debug port.

Parameters:
- DATA_BITS, 8, data bits per frame, LSB first.
- OVERSAMPLE, 16, baud_tick pulses per bit period; must be even and >= 4.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- baud_tick  input  1  single-cycle pulse, OVERSAMPLE per bit period
- rx  input  1  synchronized serial line, idle high
- rx_data  output  DATA_BITS  last correctly received byte
- rx_done_tick  output  1  one-clk strobe: rx_data updated
- frame_err  output  1  one-clk strobe: stop bit sampled low
- busy  output  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset values:
  - Asynchronous reset returns the FSM to IDLE immediately, including mid-frame; the partial frame is discarded.
  - rx_data=0, rx_done_tick=0, frame_err=0, busy=0.
  - tick_cnt=0, bit_cnt=0, shift register=0, armed=0.
- Sampling: all rx sampling and counter updates happen only in clk cycles where baud_tick=1; otherwise state holds.
- armed flag:
  - Set on any baud_tick with rx=1.
  - Cleared at reset and on a frame error.
  - A start bit is accepted only when armed=1; a line held low (break) after reset or after a framing error produces no frames.
- IDLE:
  - On baud_tick with rx=0 and armed=1: go to START, tick_cnt=0.
- START:
  - Count baud_ticks; at tick_cnt=OVERSAMPLE/2-1 (mid start bit), sample rx.
  - rx=1: false start, return to IDLE, no strobe.
  - rx=0: tick_cnt=0, bit_cnt=0, go to DATA.
- DATA:
  - At tick_cnt=OVERSAMPLE-1 (mid bit): shift rx into the MSB of the shift register (right shift, so the first bit ends in bit 0), tick_cnt=0, bit_cnt+1.
  - After bit DATA_BITS-1: go to STOP (or PARITY, see Optional Feature).
- STOP: at tick_cnt=OVERSAMPLE-1, sample rx.
  - rx=1: rx_data<=shift register; rx_done_tick=1 for exactly the next clk cycle.
  - rx=0: frame_err=1 for one clk; rx_data unchanged; armed<=0.
  - Both cases: return to IDLE.
- Strobe latency: strobes are registered, asserted in the clk cycle immediately after the baud_tick cycle that sampled the stop bit. They are never asserted together and are never longer than one clk.
- Frame latency: rx_done_tick occurs about 9.5 bit periods after the start edge (8N1).
- Back-to-back frames: a start bit immediately after a stop bit is accepted, because armed is set by the stop-bit sample.
- rx_data holds its value until the next good frame; error frames never modify it.
- Counters:
  - tick_cnt width = clog2(OVERSAMPLE), wraps to 0 as specified.
  - bit_cnt width = clog2(DATA_BITS+1).

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - State PARITY is inserted between DATA and STOP; the even-parity bit is sampled at tick_cnt=OVERSAMPLE-1.
  - Output port parity_err (1 bit, reset 0) is added.
  - On mismatch (XOR of data bits and parity bit != 0), STOP still runs. At stop sample: parity_err=1 for one clk instead of rx_done_tick, and rx_data is unchanged.
  - If the frame also has a bad stop bit, frame_err takes precedence and parity_err is not asserted.
- Undefined: no PARITY state, no parity_err port; frame is 8N1.

Test Plan:
- Reset, rx=1 for 1 bit time, send 0x2B ('+') 8N1 at OVERSAMPLE=16 -> exactly one rx_done_tick, rx_data=0x2B, frame_err never high, busy low afterwards.
- Send 'H' then 'L' back-to-back with no idle gap -> two rx_done_ticks, rx_data=0x48 then 0x4C.
- rx low pulse of 4 baud_ticks, then high -> returns to IDLE after the mid-start sample; no strobes; the next frame 0xA5 is received correctly.
- Frame 0x55 with stop bit driven low -> frame_err one clk; rx_data keeps its previous value; rx held low 3 bit times produces nothing; rx high then frame 0x0F -> rx_data=0x0F.
- Assert reset during data bit 4 of 0xFF, release, send 0x3C -> all outputs 0 during reset; only 0x3C is delivered.
- With UART_RX_PARITY_EN: send 0x07 with parity bit 1 -> rx_done_tick, rx_data=0x07; with parity bit 0 -> parity_err one clk, rx_data unchanged.

Source files
------------

// File: rtl/uart_rx_os.sv
// uart_rx_os - oversampling UART receiver for the debug port command path.
//
// Takes an already-synchronized serial line and the shared baud_tick, which
// pulses OVERSAMPLE times per bit period. Each valid frame produces one
// strobed byte.
//
// Ports:
//   clk           system clock
//   reset         asynchronous, active-low reset
//   baud_tick     single-cycle pulse, OVERSAMPLE per bit period
//   rx            synchronized serial line, idle high
//   rx_data       last correctly received byte (LSB first on the wire)
//   rx_done_tick  one-clk strobe: rx_data updated
//   frame_err     one-clk strobe: stop bit sampled low
//   parity_err    one-clk strobe: even-parity mismatch (UART_RX_PARITY_EN only)
//   busy          high while a frame is in progress
//
// Build option: define UART_RX_PARITY_EN to receive 8E1 frames. This adds a
// PARITY state between DATA and STOP and adds the parity_err output.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for rx low while armed
// START  | counting to the middle of the start bit to confirm it
// DATA   | sampling data bits in the middle of each bit period
// PARITY | sampling the even-parity bit (UART_RX_PARITY_EN only)
// STOP   | sampling the stop bit, then issuing a strobe

module uart_rx_os #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 baud_tick,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_done_tick,
   output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
   output logic                 parity_err,
`endif
   output logic                 busy
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS + 1);

   localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
   localparam logic [2:0] S_PARITY = 3'd3;
`endif
   localparam logic [2:0] S_STOP   = 3'd4;

   logic [2:0]           state_q, state_d;
   logic [TW-1:0]        tick_q, tick_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 done_q, done_d;
   logic                 ferr_q, ferr_d;
   logic                 armed_q, armed_d;
`ifdef UART_RX_PARITY_EN
   logic                 perr_q, perr_d;
   logic                 par_bad_q, par_bad_d;
`endif

   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      armed_d = armed_q;
      done_d  = 1'b0;
      ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_d    = 1'b0;
      par_bad_d = par_bad_q;
`endif
      if (baud_tick) begin
         // Any high sample re-arms; this includes the stop bit itself, which
         // allows back-to-back frames.
         if (rx) armed_d = 1'b1;
         case (state_q)
            S_IDLE: begin
               if (!rx && armed_q) begin
                  state_d = S_START;
                  tick_d  = '0;
               end
            end
            S_START: begin
               if (tick_q == TICK_MID) begin
                  if (rx) begin
                     state_d = S_IDLE;
                  end else begin
                     tick_d  = '0;
                     bit_d   = '0;
                     state_d = S_DATA;
                  end
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
            S_DATA: begin
               if (tick_q == TICK_END) begin
                  shift_d = {rx, shift_q[DATA_BITS-1:1]};
                  tick_d  = '0;
                  bit_d   = bit_q + 1'b1;
                  if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                     state_d = S_PARITY;
`else
                     state_d = S_STOP;
`endif
                  end
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
               if (tick_q == TICK_END) begin
                  par_bad_d = ^{shift_q, rx};
                  tick_d    = '0;
                  state_d   = S_STOP;
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
`endif
            S_STOP: begin
               if (tick_q == TICK_END) begin
                  tick_d  = '0;
                  state_d = S_IDLE;
                  if (!rx) begin
                     // A bad stop bit outranks a parity error. Disarming
                     // keeps a held-low break from producing frames.
                     ferr_d  = 1'b1;
                     armed_d = 1'b0;
`ifdef UART_RX_PARITY_EN
                  end else if (par_bad_q) begin
                     perr_d = 1'b1;
`endif
                  end else begin
                     done_d = 1'b1;
                     data_d = shift_q;
                  end
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         tick_q    <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         done_q    <= 1'b0;
         ferr_q    <= 1'b0;
         armed_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_q    <= 1'b0;
         par_bad_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         tick_q    <= tick_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         done_q    <= done_d;
         ferr_q    <= ferr_d;
         armed_q   <= armed_d;
`ifdef UART_RX_PARITY_EN
         perr_q    <= perr_d;
         par_bad_q <= par_bad_d;
`endif
      end
   end

   assign rx_data      = data_q;
   assign rx_done_tick = done_q;
   assign frame_err    = ferr_q;
`ifdef UART_RX_PARITY_EN
   assign parity_err   = perr_q;
`endif
   assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os - scoreboard bench for uart_rx_os at OVERSAMPLE=16.
// Expected strobes are queued as frames are sent. Each strobe is checked
// against the head of the queue, so an extra strobe, a missing strobe or a
// wrong strobe kind is reported.

module tb_uart_rx_os;
   localparam int OS       = 16;
   localparam int TICK_DIV = 4;
   localparam int BIT_CLKS = OS * TICK_DIV;

   localparam logic [2:0] K_DONE = 3'b001;
   localparam logic [2:0] K_FERR = 3'b010;
   localparam logic [2:0] K_PERR = 3'b100;

   typedef struct {
      logic [2:0] kind;
      logic [7:0] data;
   } exp_t;

   logic       clk;
   logic       reset;
   logic       baud_tick;
   logic       rx;
   logic [7:0] rx_data;
   logic       rx_done_tick;
   logic       frame_err;
   logic       busy;
   logic       perr_w;

   exp_t sb_q[$];
   int   n_tests;
   int   n_fail;

   uart_rx_os #(.DATA_BITS(8), .OVERSAMPLE(OS)) dut (
      .clk          (clk),
      .reset        (reset),
      .baud_tick    (baud_tick),
      .rx           (rx),
      .rx_data      (rx_data),
      .rx_done_tick (rx_done_tick),
      .frame_err    (frame_err),
`ifdef UART_RX_PARITY_EN
      .parity_err   (perr_w),
`endif
      .busy         (busy)
   );

`ifndef UART_RX_PARITY_EN
   assign perr_w = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // baud_tick: one clk high out of every TICK_DIV, changed on negedge
   initial begin
      baud_tick = 1'b0;
      forever begin
         repeat (TICK_DIV - 1) @(negedge clk);
         baud_tick = 1'b1;
         @(negedge clk);
         baud_tick = 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic bit_wait(input int nbits);
      repeat (nbits * BIT_CLKS) @(negedge clk);
   endtask

   task automatic push(input logic [2:0] kind, input logic [7:0] data);
      exp_t e;
      e.kind = kind;
      e.data = data;
      sb_q.push_back(e);
   endtask

   task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic par_bad);
      rx = 1'b0;
      bit_wait(1);
      for (int i = 0; i < 8; i++) begin
         rx = data[i];
         bit_wait(1);
      end
`ifdef UART_RX_PARITY_EN
      rx = (^data) ^ par_bad;
      bit_wait(1);
`endif
      rx = stop_bit;
      bit_wait(1);
      rx = 1'b1;
   endtask

   // Monitor: sample away from the active edge
   always @(negedge clk) begin
      logic [2:0] kind;
      exp_t       e;
      kind = {perr_w, frame_err, rx_done_tick};
      if (kind != 3'b000) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_strobe", 32'(kind), 32'd0);
         end else begin
            e = sb_q.pop_front();
            chk("strobe_kind", 32'(kind), 32'(e.kind));
            chk("rx_data", 32'(rx_data), 32'(e.data));
         end
      end
   end

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rx      = 1'b1;
      reset   = 1'b0;
      repeat (5) @(negedge clk);
      chk("rst_rx_data", 32'(rx_data), 32'd0);
      chk("rst_done", 32'(rx_done_tick), 32'd0);
      chk("rst_ferr", 32'(frame_err), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      reset = 1'b1;
      bit_wait(1);

      // single frame; busy checked mid-frame and afterwards
      push(K_DONE, 8'h2B);
      fork
         send_frame(8'h2B, 1'b1, 1'b0);
         begin
            bit_wait(2);
            chk("busy_mid", 32'(busy), 32'd1);
         end
      join
      bit_wait(1);
      chk("busy_idle", 32'(busy), 32'd0);

      // back-to-back frames, no idle gap
      push(K_DONE, 8'h48);
      send_frame(8'h48, 1'b1, 1'b0);
      push(K_DONE, 8'h4C);
      send_frame(8'h4C, 1'b1, 1'b0);
      bit_wait(1);

      // false start: 4 ticks low
      rx = 1'b0;
      repeat (4 * TICK_DIV) @(negedge clk);
      rx = 1'b1;
      bit_wait(1);
      chk("false_start_busy", 32'(busy), 32'd0);
      push(K_DONE, 8'hA5);
      send_frame(8'hA5, 1'b1, 1'b0);
      bit_wait(1);

      // framing error, then a break that must stay silent
      push(K_FERR, 8'hA5);
      send_frame(8'h55, 1'b0, 1'b0);
      rx = 1'b0;
      bit_wait(3);
      chk("break_busy", 32'(busy), 32'd0);
      chk("break_rx_data", 32'(rx_data), 32'hA5);
      rx = 1'b1;
      bit_wait(1);
      push(K_DONE, 8'h0F);
      send_frame(8'h0F, 1'b1, 1'b0);
      bit_wait(1);

      // reset in the middle of data bit 4 of 0xFF
      rx = 1'b0;
      bit_wait(1);
      rx = 1'b1;
      bit_wait(4);
      repeat (BIT_CLKS / 2) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("midrst_rx_data", 32'(rx_data), 32'd0);
      chk("midrst_done", 32'(rx_done_tick), 32'd0);
      chk("midrst_ferr", 32'(frame_err), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      reset = 1'b1;
      bit_wait(1);
      push(K_DONE, 8'h3C);
      send_frame(8'h3C, 1'b1, 1'b0);
      bit_wait(1);

`ifdef UART_RX_PARITY_EN
      push(K_DONE, 8'h07);
      send_frame(8'h07, 1'b1, 1'b0);
      bit_wait(1);
      push(K_PERR, 8'h07);
      send_frame(8'h07, 1'b1, 1'b1);
      bit_wait(1);
      // bad parity and bad stop: frame error only
      push(K_FERR, 8'h07);
      send_frame(8'h81, 1'b0, 1'b1);
      rx = 1'b1;
      bit_wait(1);
`endif

      // every queued strobe must have arrived
      for (int i = 0; i < 20 * BIT_CLKS && sb_q.size() != 0; i++) @(negedge clk);
      chk("sb_drain", 32'(sb_q.size()), 32'd0);
      chk("final_busy", 32'(busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
